// File: rtl/vga_scanout.sv
// vga_scanout: read-side consumer of the final video FIFO. Generates VGA
// raster timing from the pixel clock, pops one pixel per active cycle once
// aligned to a frame origin, and reports FIFO underflow.
//
// Ports:
//   clk           pixel clock
//   rst           synchronous active-high reset
//   rdempty, q    show-ahead FIFO status and head pixel {R,G,B}
//   rdreq         pop request (combinational, same-edge pop)
//   vga_r/g/b     registered pixel colour
//   vga_hs/vs     registered syncs, active low
//   vga_blank_n   registered, high in the active area
//   frame_start   registered one-cycle pulse for raster origin
//   underflow     sticky underflow flag
//   underflow_cnt saturating count of underflowed pixels
//   underflow_clr clears flag and count
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [23:0] UF_COLOR = 24'hFF00FF,
  parameter int unsigned UF_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdempty,
  input  logic [23:0]         q,
  output logic                rdreq,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output logic                frame_start,
  output logic                underflow,
  output logic [UF_CNT_W-1:0] underflow_cnt,
  input  logic                underflow_clr
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [UF_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_active;
  logic          w_origin;
  logic          w_hs_n;
  logic          w_vs_n;
  logic          w_run;
  logic          w_uf_evt;
  logic [23:0]   w_pix;

  // Free-running raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_hs_n   = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign w_vs_n   = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT;
    else     r_state <= w_state_nxt;
  end

  // Next state and pop/pixel decode; the WAIT->RUN cycle already behaves as RUN
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    rdreq       = 1'b0;
    w_uf_evt    = 1'b0;
    w_pix       = '0;
    case (r_state)
      S_WAIT: begin
        if (w_origin && !rdempty) begin
          w_state_nxt = S_RUN;
          w_run       = 1'b1;
        end
      end
      S_RUN:   w_run = 1'b1;
      default: w_state_nxt = S_WAIT;
    endcase
    // An empty slot is shown as UF_COLOR and skipped, never caught up
    if (w_run && w_active && !rst) begin
      rdreq    = !rdempty;
      w_uf_evt = rdempty;
      w_pix    = rdempty ? UF_COLOR : q;
    end
  end

  // Video outputs, all one cycle behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= w_pix;
      vga_hs      <= w_hs_n;
      vga_vs      <= w_vs_n;
      vga_blank_n <= w_active;
      frame_start <= w_origin;
    end
  end

  // Underflow flag and saturating count; a same-cycle event wins over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (underflow_clr) begin
      underflow     <= w_uf_evt;
      underflow_cnt <= w_uf_evt ? UF_CNT_W'(1) : '0;
    end else if (w_uf_evt) begin
      underflow <= 1'b1;
      if (underflow_cnt != CNT_MAX) underflow_cnt <= underflow_cnt + UF_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout on a reduced raster geometry so whole frames run
// quickly; the behavioural model derives raster position from elapsed cycles.
module tb_vga_scanout;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [23:0] UF = 24'hFF00FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdempty = 1'b1;
  logic [23:0] q = '0;
  logic underflow_clr = 1'b0;
  logic rdreq;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_blank_n, frame_start, underflow;
  logic [CW-1:0] underflow_cnt;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .UF_COLOR(UF), .UF_CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .rdempty(rdempty), .q(q), .rdreq(rdreq),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .frame_start(frame_start), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and stimulus controls
  logic [23:0] fifo[$];
  bit force_empty = 1'b0;
  bit auto_fill = 1'b0;

  // Model state
  int m_t = 0;
  bit m_run = 1'b0;
  bit m_uf = 1'b0;
  int m_cnt = 0;
  int m_pops = 0;
  logic [23:0] e_rgb;
  bit e_hs, e_vs, e_bl, e_fs;

  // Per-cycle disagreement tallies and observations
  int bad_rdreq = 0, bad_rgb = 0, bad_sync = 0, bad_uf = 0;
  int n_pops = 0;
  int g_tick = 0;
  int fs_prev = -1;
  int fs_period = 0;

  // One pixel clock: drive inputs, predict, sample rdreq, clock, compare registered outputs
  task automatic tick(input bit clr, input bit rs);
    int h, v;
    bit act, org, emp, ev, exp_rq;
    logic rq;
    logic [23:0] head;
    if (auto_fill) while (fifo.size() < 4) fifo.push_back(24'($urandom));
    emp  = force_empty || (fifo.size() == 0);
    head = (fifo.size() != 0) ? fifo[0] : 24'($urandom);
    rst = rs; rdempty = emp; q = head; underflow_clr = clr;
    #1;
    h = m_t % HT;
    v = (m_t / HT) % VT;
    act = (h < HA) && (v < VA);
    org = (h == 0) && (v == 0);
    if (rs) begin
      exp_rq = 1'b0; m_run = 1'b0; m_uf = 1'b0; m_cnt = 0;
      e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fs = 1'b0;
    end else begin
      if (!m_run && org && !emp) m_run = 1'b1;
      exp_rq = m_run && act && !emp;
      ev     = m_run && act && emp;
      e_rgb  = (m_run && act) ? (emp ? UF : head) : 24'h0;
      e_hs   = !(h >= HA + HFP && h < HA + HFP + HSY);
      e_vs   = !(v >= VA + VFP && v < VA + VFP + VSY);
      e_bl   = act;
      e_fs   = org;
      if (clr) begin
        m_uf = ev; m_cnt = ev ? 1 : 0;
      end else if (ev) begin
        m_uf = 1'b1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    rq = rdreq;
    if (rq !== exp_rq) bad_rdreq++;
    if (exp_rq) m_pops++;
    @(posedge clk);
    #1;
    if (rq === 1'b1) begin
      n_pops++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    if ({vga_r, vga_g, vga_b} !== e_rgb) bad_rgb++;
    if (vga_hs !== e_hs || vga_vs !== e_vs || vga_blank_n !== e_bl || frame_start !== e_fs) bad_sync++;
    if (underflow !== m_uf || underflow_cnt !== CW'(m_cnt)) bad_uf++;
    if (frame_start === 1'b1) begin
      if (fs_prev >= 0) fs_period = g_tick - fs_prev;
      fs_prev = g_tick;
    end
    g_tick++;
    m_t = rs ? 0 : m_t + 1;
  endtask

  // Advance (unchecked beyond the per-cycle tallies) to a raster position
  task automatic run_to(input int th, input int tv);
    for (int k = 0; k < FRAME; k++) begin
      if ((m_t % HT) == th && ((m_t / HT) % VT) == tv) break;
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    force_empty = 1'b1;
    bad_rdreq = 0; bad_rgb = 0; bad_sync = 0; bad_uf = 0;
    repeat (3) tick(1'b0, 1'b1);
    checks++; if (rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got %b want 0", rdreq); end
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", {vga_r, vga_g, vga_b}); end
    checks++; if ({vga_hs, vga_vs, vga_blank_n, frame_start} !== 4'b1100) begin
      errors++; $display("FAIL reset_sync hs,vs,blank_n,fs got %b want 1100", {vga_hs, vga_vs, vga_blank_n, frame_start}); end
    checks++; if (underflow !== 1'b0 || underflow_cnt !== '0) begin
      errors++; $display("FAIL reset_uf got flag %b cnt %0d want 0 0", underflow, underflow_cnt); end
    force_empty = 1'b0;
  endtask

  task automatic test_ramp();
    bad_rdreq = 0; bad_rgb = 0; bad_sync = 0; bad_uf = 0;
    fifo.delete();
    for (int i = 0; i < 2 * HA * VA; i++) fifo.push_back(24'(i));
    n_pops = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 1'b0);
      if (i == HT) begin
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'(HA)) begin
          errors++; $display("FAIL ramp_line1_px0 got %0d want %0d", {vga_r, vga_g, vga_b}, HA); end
      end
      if (i == 2 * HT + 5) begin
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'(2 * HA + 5)) begin
          errors++; $display("FAIL ramp_line2_px5 got %0d want %0d", {vga_r, vga_g, vga_b}, 2 * HA + 5); end
      end
    end
    checks++; if (n_pops != HA * VA) begin errors++; $display("FAIL ramp_pops got %0d want %0d", n_pops, HA * VA); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ramp_underflow got %b want 0", underflow); end
    checks++; if (bad_rdreq + bad_rgb + bad_sync + bad_uf != 0) begin
      errors++; $display("FAIL ramp_stream rdreq %0d rgb %0d sync %0d uf %0d want all 0", bad_rdreq, bad_rgb, bad_sync, bad_uf); end
  endtask

  task automatic test_sync();
    int hs_first, hs_len, vs_low, fs_cnt;
    hs_first = -1; hs_len = 0; vs_low = 0; fs_cnt = 0;
    bad_rdreq = 0; bad_rgb = 0; bad_sync = 0; bad_uf = 0;
    n_pops = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 1'b0);
      if (i < HT && vga_hs === 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_len++;
      end
      if (vga_vs === 1'b0) vs_low++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    checks++; if (hs_first != HA + HFP || hs_len != HSY) begin
      errors++; $display("FAIL sync_hs start %0d len %0d want %0d %0d", hs_first, hs_len, HA + HFP, HSY); end
    checks++; if (vs_low != VSY * HT) begin errors++; $display("FAIL sync_vs_low got %0d want %0d", vs_low, VSY * HT); end
    checks++; if (fs_cnt != 1 || fs_period != FRAME) begin
      errors++; $display("FAIL sync_frame_start count %0d period %0d want 1 %0d", fs_cnt, fs_period, FRAME); end
    checks++; if (n_pops != HA * VA) begin errors++; $display("FAIL sync_pops got %0d want %0d", n_pops, HA * VA); end
    checks++; if (bad_rdreq + bad_rgb + bad_sync + bad_uf != 0) begin
      errors++; $display("FAIL sync_stream rdreq %0d rgb %0d sync %0d uf %0d want all 0", bad_rdreq, bad_rgb, bad_sync, bad_uf); end
  endtask

  task automatic test_empty_origin();
    bad_rdreq = 0; bad_rgb = 0; bad_sync = 0; bad_uf = 0;
    fifo.delete();
    tick(1'b0, 1'b1);
    n_pops = 0;
    repeat (FRAME / 2) tick(1'b0, 1'b0);
    for (int i = 0; i < 2 * HA * VA; i++) fifo.push_back(24'($urandom));
    repeat (FRAME - FRAME / 2) tick(1'b0, 1'b0);
    checks++; if (n_pops != 0) begin errors++; $display("FAIL empty_origin_wait_pops got %0d want 0", n_pops); end
    n_pops = 0;
    repeat (FRAME) tick(1'b0, 1'b0);
    checks++; if (n_pops != HA * VA) begin errors++; $display("FAIL empty_origin_run_pops got %0d want %0d", n_pops, HA * VA); end
    checks++; if (bad_rdreq + bad_rgb + bad_sync + bad_uf != 0) begin
      errors++; $display("FAIL empty_origin_stream rdreq %0d rgb %0d sync %0d uf %0d want all 0", bad_rdreq, bad_rgb, bad_sync, bad_uf); end
  endtask

  task automatic test_underflow_gap();
    int uf_px, h, v;
    bit gap;
    uf_px = 0;
    bad_rdreq = 0; bad_rgb = 0; bad_sync = 0; bad_uf = 0;
    auto_fill = 1'b1;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL gap_pre_flag got %b want 0", underflow); end
    n_pops = 0;
    for (int i = 0; i < FRAME; i++) begin
      h = m_t % HT; v = (m_t / HT) % VT;
      gap = (v == 2) && (h >= 4) && (h <= 6);
      force_empty = gap || ((v == 2) && (h >= HA + HFP) && (h < HA + HFP + HSY));
      tick(1'b0, 1'b0);
      if (gap && {vga_r, vga_g, vga_b} === UF) uf_px++;
    end
    force_empty = 1'b0;
    checks++; if (uf_px != 3) begin errors++; $display("FAIL gap_uf_pixels got %0d want 3", uf_px); end
    checks++; if (n_pops != HA * VA - 3) begin errors++; $display("FAIL gap_pops got %0d want %0d", n_pops, HA * VA - 3); end
    checks++; if (underflow !== 1'b1 || underflow_cnt !== CW'(3)) begin
      errors++; $display("FAIL gap_uf got flag %b cnt %0d want 1 3", underflow, underflow_cnt); end
    checks++; if (bad_rdreq + bad_rgb + bad_sync + bad_uf != 0) begin
      errors++; $display("FAIL gap_stream rdreq %0d rgb %0d sync %0d uf %0d want all 0", bad_rdreq, bad_rgb, bad_sync, bad_uf); end
  endtask

  task automatic test_clr();
    run_to(3, 1);
    force_empty = 1'b1;
    tick(1'b1, 1'b0);
    force_empty = 1'b0;
    checks++; if (underflow !== 1'b1 || underflow_cnt !== CW'(1)) begin
      errors++; $display("FAIL clr_with_event got flag %b cnt %0d want 1 1", underflow, underflow_cnt); end
    tick(1'b1, 1'b0);
    checks++; if (underflow !== 1'b0 || underflow_cnt !== '0) begin
      errors++; $display("FAIL clr_alone got flag %b cnt %0d want 0 0", underflow, underflow_cnt); end
  endtask

  task automatic test_saturation();
    bad_rdreq = 0; bad_rgb = 0; bad_sync = 0; bad_uf = 0;
    force_empty = 1'b1;
    repeat (3 * FRAME) tick(1'b0, 1'b0);
    force_empty = 1'b0;
    checks++; if (underflow !== 1'b1 || underflow_cnt !== CW'(CMAX)) begin
      errors++; $display("FAIL sat_count got flag %b cnt %0d want 1 %0d", underflow, underflow_cnt, CMAX); end
    checks++; if (bad_rdreq + bad_rgb + bad_sync + bad_uf != 0) begin
      errors++; $display("FAIL sat_stream rdreq %0d rgb %0d sync %0d uf %0d want all 0", bad_rdreq, bad_rgb, bad_sync, bad_uf); end
  endtask

  task automatic test_random_gaps();
    bit c;
    bad_rdreq = 0; bad_rgb = 0; bad_sync = 0; bad_uf = 0;
    n_pops = 0; m_pops = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      force_empty = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 60) == 0);
      tick(c, 1'b0);
    end
    force_empty = 1'b0;
    checks++; if (n_pops != m_pops) begin errors++; $display("FAIL rand_pops got %0d want %0d", n_pops, m_pops); end
    checks++; if (underflow_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL rand_cnt got %0d want %0d", underflow_cnt, m_cnt); end
    checks++; if (bad_rdreq + bad_rgb + bad_sync + bad_uf != 0) begin
      errors++; $display("FAIL rand_stream rdreq %0d rgb %0d sync %0d uf %0d want all 0", bad_rdreq, bad_rgb, bad_sync, bad_uf); end
  endtask

  task automatic test_reset_midline();
    bad_rdreq = 0; bad_rgb = 0; bad_sync = 0; bad_uf = 0;
    run_to(HA / 2, 1);
    tick(1'b0, 1'b1);
    checks++; if (rdreq !== 1'b0) begin errors++; $display("FAIL midrst_rdreq got %b want 0", rdreq); end
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h0 || {vga_hs, vga_vs, vga_blank_n, frame_start} !== 4'b1100) begin
      errors++; $display("FAIL midrst_video got rgb %h sync %b want 000000 1100", {vga_r, vga_g, vga_b}, {vga_hs, vga_vs, vga_blank_n, frame_start}); end
    checks++; if (underflow !== 1'b0 || underflow_cnt !== '0) begin
      errors++; $display("FAIL midrst_uf got flag %b cnt %0d want 0 0", underflow, underflow_cnt); end
    force_empty = 1'b1;
    n_pops = 0;
    tick(1'b0, 1'b0);
    force_empty = 1'b0;
    repeat (FRAME - 1) tick(1'b0, 1'b0);
    checks++; if (n_pops != 0) begin errors++; $display("FAIL midrst_wait_pops got %0d want 0", n_pops); end
    n_pops = 0;
    repeat (FRAME) tick(1'b0, 1'b0);
    checks++; if (n_pops != HA * VA) begin errors++; $display("FAIL midrst_run_pops got %0d want %0d", n_pops, HA * VA); end
    checks++; if (bad_rdreq + bad_rgb + bad_sync + bad_uf != 0) begin
      errors++; $display("FAIL midrst_stream rdreq %0d rgb %0d sync %0d uf %0d want all 0", bad_rdreq, bad_rgb, bad_sync, bad_uf); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_sync();
    test_empty_origin();
    test_underflow_gap();
    test_clr();
    test_saturation();
    test_random_gaps();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Pixel-stream consumer on the read side of the final video FIFO, which the compositor fills with 24-bit RGB pixels in raster order. Generates 640x480@60 VGA timing from the pixel clock, pops one pixel per active-area cycle, and drives the DAC/RGB, sync and blank outputs. Detects FIFO underflow and reports it through a sticky flag and a saturating counter; emits a frame-start pulse for the rest of the video path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10; V_SYNC, 2; V_BP, 33, vertical porch/sync (lines)
- UF_COLOR, 24'hFF00FF, color driven on an underflowed pixel

Ports:
- clk  in  1  pixel clock; sole clock
- rst  in  1  synchronous, active-high reset
- rdempty  in  1  video FIFO empty (show-ahead FIFO: q valid whenever !rdempty)
- q  in  24  FIFO head pixel {R[23:16],G[15:8],B[7:0]}
- rdreq  out  1  pop FIFO head this cycle
- vga_r, vga_g, vga_b  out  8 each  pixel color
- vga_hs, vga_vs  out  1  syncs, active low
- vga_blank_n  out  1  high during active area
- frame_start  out  1  one-cycle pulse at h=0,v=0
- underflow  out  1  sticky underflow flag
- underflow_cnt  out  16  saturating count of underflowed pixels
- underflow_clr  in  1  clears flag and count

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800); v_cnt 0..V_TOTAL-1 (525), increments when h_cnt wraps; v_cnt wraps to 0 after 524. Counters free-run in every state.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs_raw low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); vs_raw low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- States: WAIT -> RUN. WAIT after reset: rdreq=0, RGB=0, syncs still generated. Transition WAIT->RUN on the cycle h_cnt=0,v_cnt=0 with !rdempty; that cycle is already a RUN cycle (pops pixel 0). If FIFO empty at frame origin, remain WAIT one more full frame. RUN exits only on rst.
- RUN, active cycle: rdreq = !rdempty (combinational); pixel = rdempty ? UF_COLOR : q. Underflow event = active && rdempty; the pixel slot is skipped, no catch-up pop.
- RUN, blanking: rdreq=0, RGB=0.
- Underflow flag/count: event sets flag, count+1 saturating at 16'hFFFF. underflow_clr alone: flag=0, count=0. clr and event same cycle: flag=1, count=1. Events in WAIT never counted.
- frame_start pulses at h_cnt=0,v_cnt=0 in both states.

## Timing
- Reset: h_cnt=v_cnt=0, state WAIT, vga_hs=vga_vs=1, vga_blank_n=0, RGB=0, rdreq=0, frame_start=0, underflow=0, underflow_cnt=0.
- rdreq combinational from registered counters, state and rdempty; pop takes effect on the same clk edge.
- RGB, hs, vs, blank_n and frame_start all registered: one-cycle latency from counter value, mutually aligned. Pixel popped at h_cnt=N appears on vga_* at the next cycle, with blank_n for h_cnt=N.
- Underflow flag/count update on the edge following the event.
- Reset mid-frame: all outputs return to reset values next edge; re-alignment only via WAIT at next frame origin.

## Test plan
- Reset then FIFO preloaded with 640x480 ramp (pixel = index): WAIT->RUN at first origin; exactly 307200 rdreq pulses per frame; vga_r/g/b at line 1 px 0 = 24'd640 one cycle after h_cnt=0,v_cnt=1; underflow stays 0.
- Sync geometry: hs low for 96 clocks starting 657 clocks after line start (registered), vs low for 2 lines (1600 clocks); frame length 420000 clocks; frame_start period 420000.
- FIFO empty at first origin, filled mid-frame: no rdreq until the next origin; RUN entered there.
- Force rdempty for 3 active cycles in line 10: RGB = FF00FF for those 3 pixels, no rdreq then, underflow=1, underflow_cnt=3; rdempty during blanking adds nothing.
- underflow_clr concurrent with an underflow event: flag=1, count=1; clr alone: both 0. Force 70000 events: count saturates at 65535.
- Assert rst mid-line in RUN: next cycle all outputs at reset values, rdreq=0 until next origin with !rdempty.
